// File: rtl/latency_release_fifo.sv
// rtl/latency_release_fifo.sv - in-order release FIFO with per-entry delay counters
module latency_release_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 16,
  parameter int DELAY_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [DELAY_WIDTH-1:0]   in_delay,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0]  data_mem  [DEPTH];
  logic [DELAY_WIDTH-1:0] delay_mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [DEPTH-1:0]       occupied;
  logic                   push;
  logic                   pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0) && (delay_mem[rd_ptr] == '0);
  assign out_data  = data_mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin : occ_calc
    logic [AW-1:0] offset;
    occupied = '0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset      = AW'(i) - rd_ptr;
      occupied[i] = ({1'b0, offset} < count);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i]  <= '0;
        delay_mem[i] <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Counters saturate at zero so arbitrarily long stalls are harmless.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == AW'(i))) begin
          data_mem[i]  <= in_data;
          delay_mem[i] <= in_delay;
        end else if (occupied[i] && (delay_mem[i] != '0)) begin
          delay_mem[i] <= delay_mem[i] - DELAY_WIDTH'(1);
        end
      end
    end
  end

endmodule
